// File: rtl/synth_pkg.sv
// Shared types and constants for the sound-synth blocks.
// LFSR helpers are only used by note_sequencer when NOTE_SEQ_RANDOM_EN is defined.
package synth_pkg;

  localparam int FREQ_BITS_DEFAULT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic                         rest;
    logic [FREQ_BITS_DEFAULT-1:0] note;
  } seq_step_t;

  // Default 8-bit LFSR (STEPS=8): x^8+x^6+x^5+x^4+1, Fibonacci, shift-left.
  localparam logic [7:0] LFSR_TAPS_8 = 8'hB8;
  localparam logic [7:0] LFSR_SEED_8 = 8'hFE;

  function automatic logic [15:0] lfsr_taps(input int width);
    case (width)
      6:       return 16'h0030;
      7:       return 16'h0060;
      9:       return 16'h0110;
      default: return {8'h00, LFSR_TAPS_8};
    endcase
  endfunction

  function automatic logic [15:0] lfsr_seed(input int width);
    return 16'((32'd1 << width) - 32'd2);
  endfunction

  // Gate is open while the tick count is below (gate_len+1)*(tempo+1);
  // gate_len=3 means the whole step, which also covers the 64-tick case.
  function automatic logic gate_open(input logic [5:0] tis, input logic [3:0] tp,
                                     input logic [1:0] gl);
    logic [5:0] thr;
    thr = ({4'b0, gl} + 6'd1) * ({2'b0, tp} + 6'd1);
    return (gl == 2'd3) || (tis < thr);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: pulses tick for one cycle every TICK_DIV enabled cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_reg;

  assign tick = en && (count_reg == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= tick ? '0 : count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Programmable step sequencer driving tone_freq_bin and the envelope gate (hold).
// Define NOTE_SEQ_RANDOM_EN to add LFSR-driven random step order (mode_random).
module note_sequencer
  import synth_pkg::*;
#(
  parameter int STEPS     = 8,
  parameter int FREQ_BITS = FREQ_BITS_DEFAULT,
  parameter int TICK_DIV  = 10000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic [3:0]               tempo,
  input  logic [1:0]               gate_len,
  input  logic                     mode_random,
  input  logic                     wr_en,
  input  logic [$clog2(STEPS)-1:0] wr_addr,
  input  logic [FREQ_BITS-1:0]     wr_note,
  input  logic                     wr_rest,
  output logic [FREQ_BITS-1:0]     tone_freq_bin,
  output logic                     hold,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     step_strobe
);
  localparam int SW = $clog2(STEPS);

  typedef struct packed {
    logic                 rest;
    logic [FREQ_BITS-1:0] note;
  } entry_t;

  seq_state_t           state_reg, state_next;
  entry_t               pattern_reg [STEPS];
  entry_t               fetched;
  logic                 tick, start, boundary, step_start;
  logic [SW-1:0]        next_step;
  logic [SW-1:0]        step_reg, step_next;
  logic [FREQ_BITS-1:0] tone_reg, tone_next;
  logic                 hold_reg, hold_next;
  logic                 strobe_reg, strobe_next;
  logic                 rest_reg, rest_next;
  logic [5:0]           tis_reg, tis_next;
  logic [3:0]           tempo_reg, tempo_next;
  logic [1:0]           gate_reg, gate_next;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_reg == PLAY),
    .clr  (start),
    .tick (tick)
  );

  // Last tick of a step is 4*(tempo+1)-1 = {tempo, 2'b11}.
  assign start      = (state_reg == IDLE) && run;
  assign boundary   = (state_reg == PLAY) && run && tick && (tis_reg == {tempo_reg, 2'b11});
  assign step_start = start || boundary;

`ifdef NOTE_SEQ_RANDOM_EN
  localparam int LW = SW + 5;
  localparam logic [LW-1:0] LFSR_TAPS = LW'(lfsr_taps(LW));
  localparam logic [LW-1:0] LFSR_SEED = LW'(lfsr_seed(LW));

  logic [LW-1:0] lfsr_reg, lfsr_next, lfsr_shift;

  assign lfsr_shift = {lfsr_reg[LW-2:0], ^(lfsr_reg & LFSR_TAPS)};

  always_comb begin
    lfsr_next = lfsr_reg;
    if (start) begin
      lfsr_next = LFSR_SEED;
    end else if (boundary) begin
      lfsr_next = lfsr_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  assign next_step = start ? '0 : (mode_random ? lfsr_shift[SW-1:0] : step_reg + SW'(1));
`else
  logic unused_mode_random;
  assign unused_mode_random = mode_random;
  assign next_step = start ? '0 : step_reg + SW'(1);
`endif

  // A write landing on the step being fetched is forwarded so it plays now.
  assign fetched = (wr_en && (wr_addr == next_step)) ? entry_t'{rest: wr_rest, note: wr_note}
                                                     : pattern_reg[next_step];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STEPS; i++) begin
        pattern_reg[i] <= entry_t'{rest: 1'b1, note: '0};
      end
    end else if (wr_en) begin
      pattern_reg[wr_addr] <= entry_t'{rest: wr_rest, note: wr_note};
    end
  end

  always_comb begin
    state_next  = state_reg;
    step_next   = step_reg;
    tone_next   = tone_reg;
    rest_next   = rest_reg;
    tempo_next  = tempo_reg;
    gate_next   = gate_reg;
    tis_next    = tis_reg;
    strobe_next = 1'b0;
    case (state_reg)
      IDLE:    if (run)  state_next = PLAY;
      PLAY:    if (!run) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (step_start) begin
      step_next   = next_step;
      tone_next   = fetched.note;
      rest_next   = fetched.rest;
      tempo_next  = tempo;
      gate_next   = gate_len;
      tis_next    = '0;
      strobe_next = 1'b1;
    end else if ((state_reg == PLAY) && run && tick) begin
      tis_next = tis_reg + 6'd1;
    end
    hold_next = (state_next == PLAY) && !rest_next && gate_open(tis_next, tempo_next, gate_next);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      step_reg   <= '0;
      tone_reg   <= '0;
      rest_reg   <= 1'b1;
      tempo_reg  <= '0;
      gate_reg   <= '0;
      tis_reg    <= '0;
      hold_reg   <= 1'b0;
      strobe_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      step_reg   <= step_next;
      tone_reg   <= tone_next;
      rest_reg   <= rest_next;
      tempo_reg  <= tempo_next;
      gate_reg   <= gate_next;
      tis_reg    <= tis_next;
      hold_reg   <= hold_next;
      strobe_reg <= strobe_next;
    end
  end

  assign tone_freq_bin = tone_reg;
  assign hold          = hold_reg;
  assign step_idx      = step_reg;
  assign step_strobe   = strobe_reg;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer with TICK_DIV=2 (random-order phase under NOTE_SEQ_RANDOM_EN).
`timescale 1ns/1ps
module tb_note_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [3:0] tempo = 4'd0;
  logic [1:0] gate_len = 2'd0;
  logic       mode_random = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [3:0] wr_note = 4'd0;
  logic       wr_rest = 1'b0;
  logic [3:0] tone_freq_bin;
  logic       hold;
  logic [2:0] step_idx;
  logic       step_strobe;

  note_sequencer #(.STEPS(8), .FREQ_BITS(4), .TICK_DIV(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .tempo        (tempo),
    .gate_len     (gate_len),
    .mode_random  (mode_random),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_note      (wr_note),
    .wr_rest      (wr_rest),
    .tone_freq_bin(tone_freq_bin),
    .hold         (hold),
    .step_idx     (step_idx),
    .step_strobe  (step_strobe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int         at;
    logic [2:0] idx;
    logic [3:0] note;
    logic       hld;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] pat_note [8];
  logic       pat_rest [8];

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int at, input int idx);
    exp_t e;
    e.at   = at;
    e.idx  = 3'(idx);
    e.note = pat_note[idx];
    e.hld  = !pat_rest[idx];
    sb_q.push_back(e);
  endtask

  task automatic write_step(input int a, input int n, input logic r);
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_note = 4'(n);
    wr_rest = r;
    @(negedge clk);
    wr_en = 1'b0;
    pat_note[a] = 4'(n);
    pat_rest[a] = r;
  endtask

  // Monitor: every strobe must match the oldest expected step start.
  always @(negedge clk) begin
    if (step_strobe === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: step_idx=%0d tone=%0d at cycle %0d, none expected",
                 step_idx, tone_freq_bin, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        $display("step %0d tone %0d hold %0d at cycle %0d", step_idx, tone_freq_bin, hold, cyc);
        check("strobe_cycle", cyc, mon_e.at);
        check("strobe_step_idx", int'(step_idx), int'(mon_e.idx));
        check("strobe_tone", int'(tone_freq_bin), int'(mon_e.note));
        check("strobe_hold", int'(hold), int'(mon_e.hld));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required earlier finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int t1;
    logic [7:0] lf;
    int ridx;
    for (int i = 0; i < 8; i++) begin
      pat_note[i] = 4'd0;
      pat_rest[i] = 1'b1;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_tone", int'(tone_freq_bin), 0);
    check("reset_hold", int'(hold), 0);
    check("reset_step_idx", int'(step_idx), 0);
    check("reset_strobe", int'(step_strobe), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic playback: 3,5,7,9,1,2,4,6 wrapping back to 3
    write_step(0, 3, 1'b0); write_step(1, 5, 1'b0); write_step(2, 7, 1'b0);
    write_step(3, 9, 1'b0); write_step(4, 1, 1'b0); write_step(5, 2, 1'b0);
    write_step(6, 4, 1'b0); write_step(7, 6, 1'b0);
    tempo = 4'd0; gate_len = 2'd1;
    t0 = cyc;
    for (int j = 0; j < 9; j++) push(t0 + 1 + 8 * j, j % 8);
    run = 1'b1;
    for (int k = 1; k <= 72; k++) begin
      @(negedge clk);
      check("basic_hold", int'(hold), int'(((k - 1) % 8) < 4));
    end
    run = 1'b0;  // coincides with a step boundary: no strobe expected
    @(negedge clk);
    check("stop_hold", int'(hold), 0);
    check("stop_step_idx", int'(step_idx), 0);
    check("stop_tone", int'(tone_freq_bin), 3);

    // Write collision on step 4 fetch, then stop during step 5 and restart
    pat_note[4] = 4'd12;
    t0 = cyc;
    for (int j = 0; j < 6; j++) push(t0 + 1 + 8 * j, j);
    run = 1'b1;
    for (int k = 1; k <= 43; k++) begin
      @(negedge clk);
      check("collide_hold", int'(hold), int'(((k - 1) % 8) < 4));
      if (k == 32) begin
        wr_en = 1'b1; wr_addr = 3'd4; wr_note = 4'd12; wr_rest = 1'b0;
      end
      if (k == 33) wr_en = 1'b0;
    end
    run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stop5_hold", int'(hold), 0);
      check("stop5_step_idx", int'(step_idx), 5);
      check("stop5_tone", int'(tone_freq_bin), 2);
    end
    t1 = cyc;
    push(t1 + 1, 0);
    run = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) check("restart_step_idx", int'(step_idx), 0);
    end
    run = 1'b0;
    @(negedge clk);

    // Rest and legato: step 2 silent, full-length gate
    write_step(2, 7, 1'b1);
    gate_len = 2'd3;
    t0 = cyc;
    for (int j = 0; j < 4; j++) push(t0 + 1 + 8 * j, j);
    run = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      check("legato_hold", int'(hold), int'(((k - 1) / 8) != 2));
    end
    run = 1'b0;
    @(negedge clk);
    check("legato_stop_hold", int'(hold), 0);

    // Slower tempo: 16-cycle steps, 4-cycle gate
    tempo = 4'd1; gate_len = 2'd0;
    t0 = cyc;
    push(t0 + 1, 0);
    push(t0 + 17, 1);
    run = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      check("tempo1_hold", int'(hold), int'(((k - 1) % 16) < 4));
    end
    run = 1'b0;
    @(negedge clk);

`ifdef NOTE_SEQ_RANDOM_EN
    // Random order from seed 8'hFE, x^8+x^6+x^5+x^4+1
    write_step(2, 7, 1'b0);
    tempo = 4'd0; gate_len = 2'd1; mode_random = 1'b1;
    t0 = cyc;
    lf = 8'hFE;
    ridx = 0;
    for (int j = 0; j < 32; j++) begin
      push(t0 + 1 + 8 * j, ridx);
      lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
      ridx = int'(lf[2:0]);
    end
    run = 1'b1;
    for (int k = 1; k <= 256; k++) @(negedge clk);
    run = 1'b0;
    mode_random = 1'b0;
    @(negedge clk);
`endif

    // Reset mid-play during step 1, then replay a cleared pattern
    tempo = 4'd0; gate_len = 2'd1;
    t0 = cyc;
    push(t0 + 1, 0);
    push(t0 + 9, 1);
    run = 1'b1;
    for (int k = 1; k <= 12; k++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_tone", int'(tone_freq_bin), 0);
    check("midreset_hold", int'(hold), 0);
    check("midreset_step_idx", int'(step_idx), 0);
    check("midreset_strobe", int'(step_strobe), 0);
    for (int i = 0; i < 8; i++) begin
      pat_note[i] = 4'd0;
      pat_rest[i] = 1'b1;
    end
    rst_n = 1'b1;
    push(t0 + 14, 0);
    push(t0 + 22, 1);
    push(t0 + 30, 2);
    for (int k = 14; k <= 36; k++) begin
      @(negedge clk);
      check("cleared_hold", int'(hold), 0);
    end
    run = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
